// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with programmable wait states.
// One request in flight; single-cycle response pulse.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic go;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [DEPTH];

  logic              c_we;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic              c_err;
  logic [ADDR_W-1:0] c_idx;
  logic [31:0]       old;
  logic [31:0]       merged;

  // With zero wait states the commit edge is the accept edge,
  // so the live request feeds the datapath while idle.
  assign c_we    = (state == IDLE) ? req_we    : we_q;
  assign c_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign c_be    = (state == IDLE) ? req_be    : be_q;

  assign c_idx = c_addr[ADDR_W+1:2];
  assign c_err = (|c_addr[1:0]) || (|c_addr[31:ADDR_W+2]);
  assign old   = mem[c_idx];

  always_comb begin
    merged = old;
    for (int i = 0; i < 4; i++) begin
      if (c_be[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    go        = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_n = RESP;
            go      = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CW'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (cnt <= CW'(1)) begin
          state_n = RESP;
          go      = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (go) begin
        rsp_err   <= c_err;
        rsp_rdata <= c_err ? 32'h0 : (c_we ? merged : old);
      end
    end
  end

  // Array is not reset; a held reset blocks any pending commit.
  always_ff @(posedge clk) begin
    if (go && c_we && !c_err && !rst) mem[c_idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder,
// LATENCY=2 and LATENCY=0 instances.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid, we, ready, rv, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  logic        v0, we0, rdy0, rv0, er0;
  logic [31:0] a0, wd0, rd0;
  logic [3:0]  be0;

  int passed = 0;
  int total  = 0;
  logic [32:0] sb[$];
  logic [32:0] sb0[$];

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(valid), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_be(be), .req_ready(ready),
    .rsp_valid(rv), .rsp_rdata(rdata), .rsp_err(err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_we(we0), .req_addr(a0),
    .req_wdata(wd0), .req_be(be0), .req_ready(rdy0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, o, e);
  endtask

  task automatic txn(input string tag, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] er,
                     input logic ee);
    int n;
    int k;
    logic [32:0] ex;
    sb.push_back({ee, er});
    @(negedge clk);
    valid = 1'b1; we = w; addr = a; wdata = d; be = b;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    k = 1;
    while (!rv && k < 10) begin
      @(negedge clk);
      k++;
    end
    ex = sb.pop_front();
    chk({tag, ".lat"}, k, 3);
    chk({tag, ".rdata"}, rdata, ex[31:0]);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, ex[32]});
    @(negedge clk);
    chk({tag, ".pulse"}, {30'b0, rv, ready}, 32'h1);
  endtask

  logic        s_we [3];
  logic [31:0] s_a  [3];
  logic [31:0] s_d  [3];
  int pc[8];
  int ac[8];
  int np, na, ri;
  logic adv;
  logic [32:0] ex;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    valid = 0; we = 0; addr = 0; wdata = 0; be = 0;
    v0 = 0; we0 = 0; a0 = 0; wd0 = 0; be0 = 0;
    #1;
    chk("rst.ctl", {30'b0, ready, rv}, 32'h2);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.err", {31'b0, err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    txn("st10", 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0);
    txn("ld10", 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    txn("be5", 1, 32'h10, 32'h11223344, 4'b0101, 32'hDE22BE44, 0);
    txn("ld10b", 0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 0);
    txn("be0", 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'hDE22BE44, 0);

    txn("st0", 1, 32'h0, 32'h13579BDF, 4'hF, 32'h13579BDF, 0);
    txn("mis", 0, 32'h12, 32'h0, 4'hF, 32'h0, 1);
    txn("oor", 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    txn("ld0", 0, 32'h0, 32'h0, 4'hF, 32'h13579BDF, 0);

    // held-valid stream on the LATENCY=2 instance
    s_we[0] = 1; s_a[0] = 32'h40; s_d[0] = 32'hA5A50F0F;
    s_we[1] = 0; s_a[1] = 32'h40; s_d[1] = 32'h0;
    s_we[2] = 0; s_a[2] = 32'h41; s_d[2] = 32'h0;
    sb.push_back({1'b0, 32'hA5A50F0F});
    sb.push_back({1'b0, 32'hA5A50F0F});
    sb.push_back({1'b1, 32'h0});
    @(negedge clk);
    ri = 0; adv = 0; np = 0;
    valid = 1; we = s_we[0]; addr = s_a[0]; wdata = s_d[0]; be = 4'hF;
    for (int c = 0; c < 24; c++) begin
      if (adv) begin
        ri++;
        adv = 0;
        if (ri < 3) begin
          we = s_we[ri]; addr = s_a[ri]; wdata = s_d[ri];
        end else begin
          valid = 0;
        end
      end
      if (valid && ready) adv = 1;
      if (rv) begin
        ex = (sb.size() > 0) ? sb.pop_front() : 33'h1DEADDEAD;
        chk("str.rdata", rdata, ex[31:0]);
        chk("str.err", {31'b0, err}, {31'b0, ex[32]});
        chk("str.ready", {31'b0, ready}, 32'h0);
        if (np < 8) pc[np] = c;
        np++;
      end
      @(negedge clk);
    end
    chk("str.count", np, 3);
    chk("str.gap1", pc[1] - pc[0], 4);
    chk("str.gap2", pc[2] - pc[1], 4);

    // held-valid stream on the LATENCY=0 instance
    s_we[0] = 1; s_a[0] = 32'h8; s_d[0] = 32'h55AA55AA;
    s_we[1] = 0; s_a[1] = 32'h8; s_d[1] = 32'h0;
    s_we[2] = 0; s_a[2] = 32'h9; s_d[2] = 32'h0;
    sb0.push_back({1'b0, 32'h55AA55AA});
    sb0.push_back({1'b0, 32'h55AA55AA});
    sb0.push_back({1'b1, 32'h0});
    ri = 0; adv = 0; np = 0; na = 0;
    v0 = 1; we0 = s_we[0]; a0 = s_a[0]; wd0 = s_d[0]; be0 = 4'hF;
    for (int c = 0; c < 16; c++) begin
      if (adv) begin
        ri++;
        adv = 0;
        if (ri < 3) begin
          we0 = s_we[ri]; a0 = s_a[ri]; wd0 = s_d[ri];
        end else begin
          v0 = 0;
        end
      end
      if (rv0) begin
        ex = (sb0.size() > 0) ? sb0.pop_front() : 33'h1DEADDEAD;
        chk("l0.rdata", rd0, ex[31:0]);
        chk("l0.err", {31'b0, er0}, {31'b0, ex[32]});
        if (np < 8) pc[np] = c;
        np++;
      end
      if (v0 && rdy0) begin
        adv = 1;
        if (na < 8) ac[na] = c;
        na++;
      end
      @(negedge clk);
    end
    chk("l0.naccept", na, 3);
    chk("l0.nrsp", np, 3);
    chk("l0.lat", pc[0] - ac[0], 1);
    chk("l0.gap1", ac[1] - ac[0], 2);
    chk("l0.gap2", ac[2] - ac[1], 2);

    // reset while a store is waiting
    txn("st20", 1, 32'h20, 32'h0, 4'hF, 32'h0, 0);
    txn("ld10c", 0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 0);
    @(negedge clk);
    valid = 1; we = 1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF;
    @(negedge clk);
    valid = 0;
    chk("abort.wait", {31'b0, ready}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("abort.ctl", {30'b0, ready, rv}, 32'h2);
    chk("abort.rdata", rdata, 32'h0);
    chk("abort.err", {31'b0, err}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort.norsp", {31'b0, rv}, 32'h0);
    end
    rst = 1'b0;
    txn("ld20", 0, 32'h20, 32'h0, 4'hF, 32'h0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MIPS32 datapath: the memory end of the load/store interface the core drives.
- Accepts one word-addressed load/store request at a time, inserts a configurable number of wait states, then returns a single-cycle response.
- Used in the top-level test harness and system integration to give the datapath realistic multi-cycle memory timing.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2, wait-state cycles between request acceptance and response (0 allowed).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  store byte enables; bit i covers bits [8i+7:8i]
- req_ready  output  1  responder can accept a request this cycle
- rsp_valid  output  1  response valid, one-cycle pulse
- rsp_rdata  output  32  load data, or the post-write word for a store
- rsp_err  output  1  request rejected: misaligned or out of range

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
- Reset does not clear memory array contents. A store latched but not yet committed when reset asserts is dropped, with no array write.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. The responder then latches req_we, req_addr, req_wdata and req_be. Inputs are ignored while req_ready = 0.
- States:
  - IDLE: req_ready = 1. On accept, go to WAIT with counter = LATENCY. If LATENCY = 0, go directly to RESP.
  - WAIT: req_ready = 0. Counter decrements each cycle. When the counter reaches 1, the next state is RESP.
  - RESP: req_ready = 0, rsp_valid = 1 for exactly one cycle. Next state is IDLE.
- Latency: rsp_valid asserts LATENCY+1 cycles after the accepting edge. The next request can be accepted one cycle after rsp_valid, which gives a throughput of one request per LATENCY+2 cycles.
- Error check, evaluated on the latched address:
  - err = (addr[1:0] != 0) || (addr[31:ADDR_W+2] != 0).
  - On err: no array access, rsp_rdata = 0, rsp_err = 1 in the RESP cycle.
- Store commit: the array is written on the edge entering RESP, only for bytes with be[i] = 1. Other bytes are unchanged. rsp_rdata returns the full merged word. A store with be = 4'b0000 is legal: no byte changes and the response returns the current word.
- Load: reads word addr[ADDR_W+1:2] on the edge entering RESP. req_be is ignored for loads.
- rsp_rdata and rsp_err hold their values after RESP until the next RESP. They are meaningful only while rsp_valid = 1.
- req_valid held high across a response is treated as a new request and accepted in the following IDLE cycle. No request is lost or duplicated.

Test Plan:
1. Reset then store/load, LATENCY=2: store addr 0x0000_0010, data 0xDEADBEEF, be 4'hF, accepted at edge N → rsp_valid at edge N+3 with rdata 0xDEADBEEF, err 0. Load 0x10 → rdata 0xDEADBEEF three cycles after accept.
2. Byte-enable merge: word 0x10 = 0xDEADBEEF; store 0x11223344 with be 4'b0101 → rsp_rdata 0xDE22BE44. A subsequent load returns 0xDE22BE44.
3. Errors: load 0x0000_0012 → err 1, rdata 0. Store to 0x0000_1000 (out of range for ADDR_W=10) → err 1, and a load of 0x0 afterwards shows word 0 unchanged.
4. Handshake/backpressure: req_valid held high for 3 distinct requests → req_ready low in WAIT/RESP; exactly 3 rsp_valid pulses, each 1 cycle wide, spaced 4 cycles apart.
5. LATENCY=0 build: load accepted at edge N → rsp_valid at edge N+1. Back-to-back accepts occur every 2 cycles.
6. Reset mid-operation: store 0xCAFEF00D to 0x20 (previously 0x0), assert rst during WAIT → outputs return to reset values immediately with no rsp_valid pulse. A subsequent load of 0x20 returns 0x00000000.
